// File: rtl/n_bit_alu_mc_if.sv
// Operand-issue and result-writeback handshake bundle for n_bit_alu_mc.
// The master is the issuing/consuming side; the slave is the ALU.
interface n_bit_alu_mc_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] ALU_Result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         div_zero;

  modport master (
    output in_valid, A, B, control, out_ready,
    input  in_ready, out_valid, ALU_Result, zero, carry, overflow, div_zero
  );

  modport slave (
    input  in_valid, A, B, control, out_ready,
    output in_ready, out_valid, ALU_Result, zero, carry, overflow, div_zero
  );
endinterface

// File: rtl/n_bit_alu_mc.sv
// Multi-cycle N-bit ALU: single-cycle logic/arith ops, iterative shift-add
// multiply and restoring divide, registered result and flags behind valid/ready.
module n_bit_alu_mc #(
  parameter int unsigned N = 32
) (
  input logic           clk,
  input logic           rst_n,
  n_bit_alu_mc_if.slave bus
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_XNOR, OP_GT, OP_AND, OP_OR,
    OP_XOR, OP_SHL, OP_SHR, OP_NOR, OP_NAND, OP_ROL, OP_ROR, OP_EQ
  } op_t;

  state_t         state, state_nx;
  op_t            op;
  logic           accept, start_mc;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic [N-1:0]   opnd;
  logic [N-1:0]   rem;
  logic [2*N-1:0] acc;
  logic [N:0]     mul_sum, div_sh, div_tr;
  logic           div_ok;
  logic [2*N-1:0] mul_nx;
  logic [N-1:0]   quo_nx, mc_res;
  logic [N:0]     add_w, sub_w;
  logic [N-1:0]   sc_res;
  logic           sc_carry, sc_ovf, sc_dz;
  logic [N-1:0]   res;
  logic           zero_r, carry_r, ovf_r, dz_r;

  assign op             = op_t'(bus.control);
  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.ALU_Result = res;
  assign bus.zero       = zero_r;
  assign bus.carry      = carry_r;
  assign bus.overflow   = ovf_r;
  assign bus.div_zero   = dz_r;

  assign accept   = bus.in_valid && (state == IDLE);
  assign start_mc = (op == OP_MUL) || ((op == OP_DIV) && (bus.B != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = start_mc ? BUSY : DONE;
      BUSY:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL, quotient in the low half for DIV.
  // Remainder stays below the divisor, so the sign of the N+1-bit trial decides the bit.
  always_comb begin
    mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx  = {mul_sum, acc[N-1:1]};
    div_sh  = {rem, acc[N-1]};
    div_tr  = div_sh - {1'b0, opnd};
    div_ok  = ~div_tr[N];
    quo_nx  = {acc[N-2:0], div_ok};
    mc_res  = is_div ? quo_nx : mul_nx[N-1:0];
  end

  always_comb begin
    add_w    = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w    = {1'b0, bus.A} - {1'b0, bus.B};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res   = add_w[N-1:0];
        sc_carry = add_w[N];
        sc_ovf   = (bus.A[N-1] == bus.B[N-1]) && (add_w[N-1] != bus.A[N-1]);
      end
      OP_SUB: begin
        sc_res   = sub_w[N-1:0];
        sc_carry = sub_w[N];
        sc_ovf   = (bus.A[N-1] != bus.B[N-1]) && (sub_w[N-1] != bus.A[N-1]);
      end
      OP_DIV: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_XNOR: sc_res = ~(bus.A ^ bus.B);
      OP_GT:   sc_res = N'(bus.A > bus.B);
      OP_AND:  sc_res = bus.A & bus.B;
      OP_OR:   sc_res = bus.A | bus.B;
      OP_XOR:  sc_res = bus.A ^ bus.B;
      OP_SHL:  sc_res = bus.A << bus.B[SW-1:0];
      OP_SHR:  sc_res = bus.A >> bus.B[SW-1:0];
      OP_NOR:  sc_res = ~(bus.A | bus.B);
      OP_NAND: sc_res = ~(bus.A & bus.B);
      OP_ROL:  sc_res = {bus.A[N-2:0], bus.A[N-1]};
      OP_ROR:  sc_res = {bus.A[0], bus.A[N-1:1]};
      OP_EQ:   sc_res = N'(bus.A == bus.B);
      default: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      opnd    <= '0;
      rem     <= '0;
      acc     <= '0;
      res     <= '0;
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          if (start_mc) begin
            cnt    <= CW'(N);
            is_div <= (op == OP_DIV);
            opnd   <= (op == OP_DIV) ? bus.B : bus.A;
            acc    <= (2*N)'((op == OP_DIV) ? bus.A : bus.B);
            rem    <= '0;
          end else begin
            res     <= sc_res;
            zero_r  <= (sc_res == '0);
            carry_r <= sc_carry;
            ovf_r   <= sc_ovf;
            dz_r    <= sc_dz;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          acc <= is_div ? {acc[2*N-1:N], quo_nx} : mul_nx;
          rem <= div_ok ? div_tr[N-1:0] : div_sh[N-1:0];
          if (cnt == CW'(1)) begin
            res     <= mc_res;
            zero_r  <= (mc_res == '0);
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            dz_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n_bit_alu_mc.sv
// Self-checking bench for n_bit_alu_mc: transaction-level reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_n_bit_alu_mc;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0] r;
    logic         z;
    logic         c;
    logic         o;
    logic         dz;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  n_bit_alu_mc_if #(.N(N)) bus ();
  n_bit_alu_mc #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op);
    longint unsigned ua = a, ub = b, full = longint'(1) << N;
    res_t x;
    x = '0;
    case (op)
      4'd0: begin
        x.r = N'(ua + ub);
        x.c = (ua + ub) >= full;
        x.o = (a[N-1] == b[N-1]) && (x.r[N-1] != a[N-1]);
      end
      4'd1: begin
        x.r = N'(ua - ub);
        x.c = ua < ub;
        x.o = (a[N-1] != b[N-1]) && (x.r[N-1] != a[N-1]);
      end
      4'd2: x.r = N'(ua * ub);
      4'd3: if (ub == 0) begin x.r = '1; x.dz = 1'b1; end else x.r = N'(ua / ub);
      4'd4: x.r = ~(a ^ b);
      4'd5: x.r = N'(ua > ub);
      4'd6: x.r = a & b;
      4'd7: x.r = a | b;
      4'd8: x.r = a ^ b;
      4'd9: x.r = N'(ua << (ub % N));
      4'd10: x.r = N'(ua >> (ub % N));
      4'd11: x.r = ~(a | b);
      4'd12: x.r = ~(a & b);
      4'd13: x.r = N'((ua << 1) | (ua >> (N - 1)));
      4'd14: x.r = N'((ua >> 1) | ((ua & 1) << (N - 1)));
      default: x.r = N'(ua == ub);
    endcase
    x.z = (x.r == '0);
    return x;
  endfunction

  function automatic int unsigned lat_of(input logic [N-1:0] b, input logic [3:0] op);
    return (op == 4'd2 || (op == 4'd3 && b != '0)) ? N + 1 : 1;
  endfunction

  // Transaction tracker: one outstanding op; valid from its latency until taken.
  logic        pending = 1'b0;
  int unsigned cyc = 0, vcyc = 0;
  res_t        exp_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else if (pending) begin
      if (cyc >= vcyc && bus.out_ready) pending = 1'b0;
      cyc++;
    end else begin
      cyc++;
      if (bus.in_valid) begin
        exp_r   = model(bus.A, bus.B, bus.control);
        vcyc    = cyc + lat_of(bus.B, bus.control) - 1;
        pending = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          64'({bus.out_valid, bus.in_ready, bus.ALU_Result, bus.zero, bus.carry, bus.overflow, bus.div_zero}),
          64'({1'b0, 1'b1, {N{1'b0}}, 4'b0000}));
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!pending));
      chk("out_valid", 64'(bus.out_valid), 64'(pending && cyc >= vcyc));
      if (pending && cyc >= vcyc)
        chk("result_flags",
            64'({bus.ALU_Result, bus.zero, bus.carry, bus.overflow, bus.div_zero}), 64'(exp_r));
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                        input res_t e, input int unsigned exp_lat, input int unsigned hold);
    int unsigned w = 0, n = 1;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.control = op; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("directed_result",
        64'({bus.ALU_Result, bus.zero, bus.carry, bus.overflow, bus.div_zero}), 64'(e));
    repeat (hold) begin
      @(negedge clk);
      chk("stall_ready_low", 64'(bus.in_ready), 64'(0));
    end
    chk("held_result", 64'(bus.ALU_Result), 64'(e.r));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ready_after_handoff", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0; bus.control = '0;

    chk("model_add",  64'(model(8'd200, 8'd100, 4'd0)), 64'({8'd44, 4'b0100}));
    chk("model_ovf",  64'(model(8'h7F, 8'h01, 4'd0)), 64'({8'h80, 4'b0010}));
    chk("model_sub0", 64'(model(8'd5, 8'd5, 4'd1)), 64'({8'd0, 4'b1000}));
    chk("model_mul",  64'(model(8'd13, 8'd11, 4'd2)), 64'({8'd143, 4'b0000}));
    chk("model_div",  64'(model(8'd200, 8'd7, 4'd3)), 64'({8'd28, 4'b0000}));
    chk("model_dz",   64'(model(8'd200, 8'd0, 4'd3)), 64'({8'hFF, 4'b0001}));
    chk("model_rol",  64'(model(8'h81, 8'd0, 4'd13)), 64'({8'h03, 4'b0000}));
    chk("model_shl",  64'(model(8'h81, 8'd3, 4'd9)), 64'({8'h08, 4'b0000}));

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(8'd200, 8'd100, 4'd0, {8'd44, 4'b0100}, 1, 0);
    run_op(8'h7F, 8'h01, 4'd0, {8'h80, 4'b0010}, 1, 0);
    run_op(8'd5, 8'd5, 4'd1, {8'd0, 4'b1000}, 1, 0);
    run_op(8'd20, 8'd20, 4'd2, {8'd144, 4'b0000}, 9, 0);
    run_op(8'd13, 8'd11, 4'd2, {8'd143, 4'b0000}, 9, 0);
    run_op(8'd200, 8'd7, 4'd3, {8'd28, 4'b0000}, 9, 0);
    run_op(8'd200, 8'd0, 4'd3, {8'hFF, 4'b0001}, 1, 0);
    run_op(8'h81, 8'd0, 4'd13, {8'h03, 4'b0000}, 1, 5);
    run_op(8'h81, 8'd3, 4'd9, {8'h08, 4'b0000}, 1, 0);
    run_op(8'h81, 8'd0, 4'd14, {8'hC0, 4'b0000}, 1, 0);
    run_op(8'hFF, 8'hFF, 4'd2, {8'h01, 4'b0000}, 9, 2);

    // Abort a divide partway through with reset; nothing may come out afterwards.
    @(negedge clk);
    bus.A = 8'd200; bus.B = 8'd7; bus.control = 4'd3; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      chk("no_valid_after_abort", 64'(bus.out_valid), 64'(0));
    end
    run_op(8'd1, 8'd1, 4'd0, {8'd2, 4'b0000}, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.A       = N'($urandom);
      bus.control = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: bus.B = '0;
        1: bus.B = bus.A;
        2: begin bus.A = '1; bus.B = N'($urandom); end
        default: bus.B = N'($urandom);
      endcase
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (N + 4) @(negedge clk);
    chk("idle_at_end", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
